// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and default sizing for the CDB broadcaster: broadcast packet,
// buffered entry layout, and a small integer helper.
package cdb_broadcaster_pkg;

    localparam int XLEN          = 32;
    localparam int ROBLEN        = 32;
    localparam int TAG_W         = $clog2(ROBLEN);
    localparam int DEF_NUM_FU    = 4;
    localparam int DEF_CDB_WIDTH = 3;
    localparam int DEF_BUF_DEPTH = 8;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } cdb_rs_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } cdb_entry_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cdb_broadcaster_fifo.sv
// Circular pending-result buffer: up to NUM_FU pushes and CDB_WIDTH pops per
// cycle, with the oldest CDB_WIDTH entries always visible for broadcast.
module cdb_broadcaster_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter int NUM_FU    = DEF_NUM_FU,
    parameter int CDB_WIDTH = DEF_CDB_WIDTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush_i,
    input  logic [$clog2(NUM_FU+1)-1:0]         push_cnt_i,
    input  cdb_entry_t [NUM_FU-1:0]             push_data_i,
    input  logic [$clog2(CDB_WIDTH+1)-1:0]      pop_cnt_i,
    output cdb_entry_t [CDB_WIDTH-1:0]          rd_data_o,
    output logic [$clog2(BUF_DEPTH):0]          count_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cdb_entry_t             mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;

    always_comb begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
            rd_data_o[k] = mem_q[PTR_W'(head_q + PTR_W'(k))];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = PTR_W'(head_q + PTR_W'(pop_cnt_i));
            tail_d  = PTR_W'(tail_q + PTR_W'(push_cnt_i));
            count_d = CNT_W'(count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_cnt_i));
        end
    end

    // Full and empty are told apart by count; the pointers wrap freely.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            assert (flush_i
                    || ((int'(pop_cnt_i) <= int'(count_q))
                        && (int'(count_q) + int'(push_cnt_i) - int'(pop_cnt_i) <= BUF_DEPTH)));
        end
    end

    always_ff @(posedge clock) begin
        if (!flush_i) begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (k < int'(push_cnt_i)) begin
                    mem_q[PTR_W'(tail_q + PTR_W'(k))] <= push_data_i[k];
                end
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmitter: merges buffered and freshly completed FU results, oldest
// first, into CDB_WIDTH registered broadcast slots with FU backpressure.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int NUM_FU    = DEF_NUM_FU,
    parameter int CDB_WIDTH = DEF_CDB_WIDTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash,
    input  logic [NUM_FU-1:0]                   fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]        fu_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]         fu_value,
    output logic [NUM_FU-1:0]                   fu_ready,
    output cdb_rs_packet_t [CDB_WIDTH-1:0]      cdb_packet,
    output logic [$clog2(BUF_DEPTH):0]          buf_count
);

    localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int PUSH_W = $clog2(NUM_FU + 1);
    localparam int POP_W  = $clog2(CDB_WIDTH + 1);

    logic [CNT_W-1:0]              count;
    logic [NUM_FU-1:0]             acc;
    cdb_entry_t [NUM_FU-1:0]       acc_list;
    cdb_entry_t [NUM_FU-1:0]       push_data;
    cdb_entry_t [CDB_WIDTH-1:0]    rd_data;
    cdb_rs_packet_t [CDB_WIDTH-1:0] pkt_d, pkt_q;
    logic [PUSH_W-1:0]             push_cnt;
    logic [POP_W-1:0]              pop_cnt;
    int                            n_acc, n_pop, n_new, n_push;

    // Ready depends only on the registered count, so a worst-case cycle
    // (all FUs accepted, nothing popped beyond CDB_WIDTH) can never overflow.
    assign fu_ready = {NUM_FU{int'(count) <= (BUF_DEPTH - NUM_FU)}};

    // Compact the accepted results into port order.
    always_comb begin
        acc      = fu_valid & fu_ready & {NUM_FU{!squash}};
        acc_list = '0;
        n_acc    = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (acc[i]) begin
                for (int j = 0; j < NUM_FU; j++) begin
                    if (j == n_acc) begin
                        acc_list[j] = '{tag: fu_tag[i], value: fu_value[i]};
                    end
                end
                n_acc = n_acc + 1;
            end
        end
    end

    // Buffered entries take the low slots; new results fill what remains,
    // and any surplus is appended to the buffer behind them.
    always_comb begin
        n_pop     = min_int(int'(count), CDB_WIDTH);
        n_new     = min_int(n_acc, CDB_WIDTH - n_pop);
        n_push    = n_acc - n_new;
        pkt_d     = '0;
        push_data = '0;
        for (int j = 0; j < CDB_WIDTH; j++) begin
            if (j < n_pop) begin
                pkt_d[j] = '{valid: 1'b1, tag: rd_data[j].tag, value: rd_data[j].value};
            end else begin
                for (int k = 0; k < NUM_FU; k++) begin
                    if ((k == j - n_pop) && (k < n_acc)) begin
                        pkt_d[j] = '{valid: 1'b1, tag: acc_list[k].tag, value: acc_list[k].value};
                    end
                end
            end
        end
        for (int k = 0; k < NUM_FU; k++) begin
            for (int m = 0; m < NUM_FU; m++) begin
                if ((k < n_push) && (m == k + n_new)) begin
                    push_data[k] = acc_list[m];
                end
            end
        end
        if (squash) begin
            pkt_d = '0;
        end
    end

    assign push_cnt = PUSH_W'(n_push);
    assign pop_cnt  = POP_W'(n_pop);

    cdb_broadcaster_fifo #(
        .NUM_FU    (NUM_FU),
        .CDB_WIDTH (CDB_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (squash),
        .push_cnt_i  (push_cnt),
        .push_data_i (push_data),
        .pop_cnt_i   (pop_cnt),
        .rd_data_o   (rd_data),
        .count_o     (count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    assign cdb_packet = pkt_q;
    assign buf_count  = count;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed self-checking bench for cdb_broadcaster: reset, single result,
// oversubscription, backpressure with pointer wrap, squash, async reset.
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    logic                         clock;
    logic                         reset;
    logic                         squash;
    logic [3:0]                   fu_valid;
    logic [3:0][TAG_W-1:0]        fu_tag;
    logic [3:0][XLEN-1:0]         fu_value;
    logic [3:0]                   fu_ready;
    cdb_rs_packet_t [2:0]         cdb_packet;
    logic [3:0]                   buf_count;

    int errors;
    int checks;

    cdb_broadcaster dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .fu_valid   (fu_valid),
        .fu_tag     (fu_tag),
        .fu_value   (fu_value),
        .fu_ready   (fu_ready),
        .cdb_packet (cdb_packet),
        .buf_count  (buf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        fu_valid = '0;
        fu_tag   = '0;
        fu_value = '0;
        squash   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic drive_all(input int first_tag, input logic [31:0] base);
        fu_valid = 4'hf;
        for (int i = 0; i < 4; i++) begin
            fu_tag[i]   = TAG_W'(first_tag + i);
            fu_value[i] = base + 32'(first_tag + i);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        drive_all(1, 32'h0);
        tick();
        tick();
        checks++;
        if (buf_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", buf_count);
        end
        checks++;
        if (fu_ready !== 4'hf) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1111", fu_ready);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (cdb_packet[j] !== '0) begin
                errors++;
                $display("FAIL reset_slot%0d: got %h expected 0", j, cdb_packet[j]);
            end
        end
        clear_inputs();
        reset = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (cdb_packet[j] !== '0) begin
                errors++;
                $display("FAIL post_reset_idle_slot%0d: got %h expected 0", j, cdb_packet[j]);
            end
        end
        checks++;
        if (buf_count !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_count: got %0d expected 0", buf_count);
        end
    endtask

    task automatic test_single();
        cdb_rs_packet_t exp;
        do_reset();
        fu_valid    = 4'b0001;
        fu_tag[0]   = 5'd5;
        fu_value[0] = 32'hDEAD;
        tick();
        clear_inputs();
        exp = '{valid: 1'b1, tag: 5'd5, value: 32'hDEAD};
        checks++;
        if (cdb_packet[0] !== exp) begin
            errors++;
            $display("FAIL single_slot0: got %h expected %h", cdb_packet[0], exp);
        end
        for (int j = 1; j < 3; j++) begin
            checks++;
            if (cdb_packet[j] !== '0) begin
                errors++;
                $display("FAIL single_slot%0d: got %h expected 0", j, cdb_packet[j]);
            end
        end
        checks++;
        if (buf_count !== 4'd0) begin
            errors++;
            $display("FAIL single_count: got %0d expected 0", buf_count);
        end
        tick();
        checks++;
        if (cdb_packet[0] !== '0) begin
            errors++;
            $display("FAIL single_no_repeat: got %h expected 0", cdb_packet[0]);
        end
    endtask

    task automatic test_oversubscription();
        cdb_rs_packet_t exp;
        do_reset();
        drive_all(1, 32'h100);
        tick();
        fu_valid    = 4'b0001;
        fu_tag[0]   = 5'd9;
        fu_value[0] = 32'h109;
        for (int j = 0; j < 3; j++) begin
            exp = '{valid: 1'b1, tag: TAG_W'(j + 1), value: 32'h100 + 32'(j + 1)};
            checks++;
            if (cdb_packet[j] !== exp) begin
                errors++;
                $display("FAIL oversub_c1_slot%0d: got %h expected %h", j, cdb_packet[j], exp);
            end
        end
        checks++;
        if (buf_count !== 4'd1) begin
            errors++;
            $display("FAIL oversub_c1_count: got %0d expected 1", buf_count);
        end
        tick();
        clear_inputs();
        exp = '{valid: 1'b1, tag: 5'd4, value: 32'h104};
        checks++;
        if (cdb_packet[0] !== exp) begin
            errors++;
            $display("FAIL oversub_c2_slot0: got %h expected %h", cdb_packet[0], exp);
        end
        exp = '{valid: 1'b1, tag: 5'd9, value: 32'h109};
        checks++;
        if (cdb_packet[1] !== exp) begin
            errors++;
            $display("FAIL oversub_c2_slot1: got %h expected %h", cdb_packet[1], exp);
        end
        checks++;
        if (cdb_packet[2] !== '0) begin
            errors++;
            $display("FAIL oversub_c2_slot2: got %h expected 0", cdb_packet[2]);
        end
        checks++;
        if (buf_count !== 4'd0) begin
            errors++;
            $display("FAIL oversub_c2_count: got %0d expected 0", buf_count);
        end
    endtask

    task automatic test_backpressure_wrap();
        int exp_cnt [7] = '{1, 2, 3, 4, 5, 2, 0};
        int exp_nv  [7] = '{3, 3, 3, 3, 3, 3, 2};
        bit exp_rdy [7] = '{1, 1, 1, 1, 1, 0, 1};
        int next_tag;
        int exp_bc;
        int nv;
        do_reset();
        next_tag = 1;
        exp_bc   = 1;
        for (int c = 0; c < 7; c++) begin
            if (c < 6) drive_all(next_tag, 32'hB000_0000);
            else clear_inputs();
            checks++;
            if (fu_ready !== (exp_rdy[c] ? 4'hf : 4'h0)) begin
                errors++;
                $display("FAIL bp_ready_c%0d: got %b expected %b", c, fu_ready, exp_rdy[c] ? 4'hf : 4'h0);
            end
            tick();
            if (c < 6 && exp_rdy[c]) next_tag += 4;
            checks++;
            if (buf_count !== 4'(exp_cnt[c])) begin
                errors++;
                $display("FAIL bp_count_c%0d: got %0d expected %0d", c, buf_count, exp_cnt[c]);
            end
            nv = 0;
            for (int j = 0; j < 3; j++) begin
                if (cdb_packet[j].valid) begin
                    checks++;
                    if (cdb_packet[j].tag !== TAG_W'(exp_bc)
                        || cdb_packet[j].value !== 32'hB000_0000 + 32'(exp_bc)) begin
                        errors++;
                        $display("FAIL bp_order_c%0d_slot%0d: got tag %0d value %h expected tag %0d value %h",
                                 c, j, cdb_packet[j].tag, cdb_packet[j].value, exp_bc,
                                 32'hB000_0000 + 32'(exp_bc));
                    end
                    exp_bc++;
                    nv++;
                end
            end
            checks++;
            if (nv != exp_nv[c]) begin
                errors++;
                $display("FAIL bp_nvalid_c%0d: got %0d expected %0d", c, nv, exp_nv[c]);
            end
        end
        clear_inputs();
        checks++;
        if (exp_bc != 21) begin
            errors++;
            $display("FAIL bp_total: got %0d broadcasts expected 20", exp_bc - 1);
        end
        tick();
        checks++;
        if (cdb_packet[0].valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained_idle: got %h expected invalid", cdb_packet[0]);
        end
    endtask

    task automatic test_squash();
        cdb_rs_packet_t exp;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive_all(4 * c + 1, 32'hC000_0000);
            tick();
        end
        checks++;
        if (buf_count !== 4'd5) begin
            errors++;
            $display("FAIL squash_prefill_count: got %0d expected 5", buf_count);
        end
        clear_inputs();
        fu_valid    = 4'b0011;
        fu_tag[0]   = 5'd30;
        fu_tag[1]   = 5'd31;
        fu_value[0] = 32'h30;
        fu_value[1] = 32'h31;
        squash      = 1'b1;
        checks++;
        if (fu_ready !== 4'h0) begin
            errors++;
            $display("FAIL squash_ready_pre: got %b expected 0000", fu_ready);
        end
        tick();
        clear_inputs();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (cdb_packet[j] !== '0) begin
                errors++;
                $display("FAIL squash_slot%0d: got %h expected 0", j, cdb_packet[j]);
            end
        end
        checks++;
        if (buf_count !== 4'd0) begin
            errors++;
            $display("FAIL squash_count: got %0d expected 0", buf_count);
        end
        checks++;
        if (fu_ready !== 4'hf) begin
            errors++;
            $display("FAIL squash_ready_post: got %b expected 1111", fu_ready);
        end
        tick();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (cdb_packet[j] !== '0) begin
                errors++;
                $display("FAIL squash_no_leak_slot%0d: got %h expected 0", j, cdb_packet[j]);
            end
        end
        fu_valid    = 4'b0100;
        fu_tag[2]   = 5'd12;
        fu_value[2] = 32'h1212;
        tick();
        clear_inputs();
        exp = '{valid: 1'b1, tag: 5'd12, value: 32'h1212};
        checks++;
        if (cdb_packet[0] !== exp || cdb_packet[1] !== '0) begin
            errors++;
            $display("FAIL squash_resume: got %h %h expected %h 0", cdb_packet[0], cdb_packet[1], exp);
        end
    endtask

    task automatic test_async_reset();
        cdb_rs_packet_t exp;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive_all(4 * c + 1, 32'hD000_0000);
            tick();
        end
        checks++;
        if (buf_count !== 4'd3) begin
            errors++;
            $display("FAIL areset_prefill_count: got %0d expected 3", buf_count);
        end
        #3;
        reset = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (cdb_packet[j] !== '0) begin
                errors++;
                $display("FAIL areset_slot%0d: got %h expected 0", j, cdb_packet[j]);
            end
        end
        checks++;
        if (buf_count !== 4'd0 || fu_ready !== 4'hf) begin
            errors++;
            $display("FAIL areset_count_ready: got %0d/%b expected 0/1111", buf_count, fu_ready);
        end
        clear_inputs();
        #2;
        reset = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (cdb_packet[j] !== '0) begin
                errors++;
                $display("FAIL areset_release_slot%0d: got %h expected 0", j, cdb_packet[j]);
            end
        end
        fu_valid    = 4'b0001;
        fu_tag[0]   = 5'd7;
        fu_value[0] = 32'h7777;
        tick();
        clear_inputs();
        exp = '{valid: 1'b1, tag: 5'd7, value: 32'h7777};
        checks++;
        if (cdb_packet[0] !== exp || cdb_packet[1] !== '0 || cdb_packet[2] !== '0) begin
            errors++;
            $display("FAIL areset_no_stale: got %h %h %h expected %h 0 0",
                     cdb_packet[0], cdb_packet[1], cdb_packet[2], exp);
        end
        checks++;
        if (buf_count !== 4'd0) begin
            errors++;
            $display("FAIL areset_final_count: got %0d expected 0", buf_count);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_oversubscription();
        test_backpressure_wrap();
        test_squash();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Transmitter side of the CDB broadcast consumed by RS lines and the ROB.
- Collects completion results (ROB tag + value) from NUM_FU functional units.
- Buffers results that cannot be broadcast yet.
- Drives up to CDB_WIDTH registered broadcast slots per cycle, oldest result first, with backpressure to the FUs.

Parameters:
- NUM_FU, 4, number of FU completion ports (ALU0, ALU1, MULT, LOAD).
- CDB_WIDTH, 3, broadcast slots per cycle; matches the RS CDB_RS_PACKET [2:0] input.
- BUF_DEPTH, 8, pending-result FIFO entries; power of 2, must be >= NUM_FU.
- TAG_W, $clog2(`ROBLEN), ROB tag width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- squash  in  1  synchronous flush on branch mispredict.
- fu_valid  in  [NUM_FU-1:0]  FU i presents a completed result.
- fu_tag  in  [NUM_FU-1:0][TAG_W-1:0]  ROB tag of the result.
- fu_value  in  [NUM_FU-1:0][`XLEN-1:0]  result value.
- fu_ready  out  [NUM_FU-1:0]  result accepted this cycle when fu_valid & fu_ready.
- cdb_packet  out  CDB_RS_PACKET [CDB_WIDTH-1:0]  registered {valid, tag, value} per slot.
- buf_count  out  $clog2(BUF_DEPTH)+1  entries currently buffered (debug/perf).

Behaviour:
- Reset (reset==0, async): FIFO head/tail/count = 0; all cdb_packet slots {0,0,0}; buf_count = 0; fu_ready = all 1.
- fu_ready: combinational from the registered count only; all bits 1 iff count <= BUF_DEPTH-NUM_FU, else all 0. No dependence on fu_valid, so there is no combinational loop.
- Accept: FU i result accepted at posedge iff fu_valid[i] && fu_ready[i] && !squash. Unaccepted results are the FU's responsibility to hold; the FU keeps valid/tag/value stable.
- Candidate order each cycle:
  - Buffered entries, oldest first (head upward, wrap modulo BUF_DEPTH).
  - Then newly accepted results, port 0 first.
- Broadcast at posedge:
  - First min(CDB_WIDTH, total candidates) are written to cdb_packet slot 0..k-1 in candidate order; slot 0 is the oldest.
  - Remaining slots are {valid=0, tag=0, value=0}.
- Latency: an accepted result with an empty buffer appears on cdb_packet the next cycle (1-cycle latency). A buffered result waits 1 cycle per CDB_WIDTH older entries ahead of it.
- Append: accepted results not broadcast are written at tail in port order. Update tail, and set count_next = count + accepted - broadcast_from_buffer.
- Wrap-around: head/tail are log2(BUF_DEPTH)-bit pointers, wrap naturally. Full/empty are distinguished by count, not by pointer equality.
- Overflow: impossible by construction of fu_ready. Assertion: count_next <= BUF_DEPTH.
- Empty + no valid: all slots invalid, state unchanged.
- Squash (sync, priority over everything except reset):
  - At posedge: head=tail=count=0, all cdb_packet slots invalid, inputs that cycle discarded.
  - fu_ready still follows the pre-squash count during the squash cycle.
- Simultaneous squash and reset: reset wins.
- No duplicate-tag or tag-0 checks: tag 0 is a legal ROB index and is broadcast like any other. Consumers qualify by valid.
- Value/tag pass through unmodified; no arithmetic on data.

Decomposition:
- sys_defs.svh: CDB_RS_PACKET {valid, tag, value} (existing), `CDB_WIDTH, `NUM_FU.
- New typedef CDB_ENTRY {tag, value} for FIFO storage.
- Sub-module: cdb_fifo (circular buffer with multi-push/multi-pop up to NUM_FU in / CDB_WIDTH out, count output). The top holds the candidate-select and output registers.

Test Plan:
- Reset: hold reset=0, drive fu_valid=4'b1111 -> cdb all valid=0, buf_count=0, fu_ready=4'b1111. After release, outputs remain idle until the next edge with valid inputs.
- Single result: fu_valid=4'b0001, tag=5, value=32'hDEAD -> next cycle slot0={1,5,DEAD}, slots1-2 invalid, buf_count=0.
- Oversubscription: all 4 FUs valid one cycle, tags 1,2,3,4 -> cycle+1 slots carry tags 1,2,3 with buf_count=1. Cycle+2, with new fu_valid=4'b0001 tag 9: slot0=tag 4, slot1=tag 9.
- Backpressure and wrap: hold all 4 FUs valid with tags incrementing each cycle.
  - buf_count rises by 1 per cycle to 5; fu_ready drops to 0 while count>4.
  - Buffer then drains 3 per cycle; head wraps past index 7.
  - Tags must appear on cdb strictly in acceptance order with no loss or duplication.
- Squash mid-drain: buf_count=5, assert squash with fu_valid=4'b0011 -> next cycle all slots invalid, buf_count=0, squashed-cycle inputs never broadcast.
- Async reset mid-operation: drop reset between clock edges while buf_count=3 -> outputs clear immediately, without waiting for an edge, and no stale tags appear after release.
